// File: rtl/rpn_stack_engine.sv
// RPN stack calculator core: DEPTH-entry operand stack, binary/unary ops,
// iterative restoring divider for DIV/MOD, sticky error flags.
module rpn_stack_engine #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_is_op,
    input  logic [WIDTH-1:0]         in_value,
    input  logic [2:0]               in_op,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     done,
    output logic                     err_full,
    output logic                     err_empty,
    output logic                     err_div0,
    output logic                     err_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [AW:0] ONE  = 1;
    localparam logic [AW:0] TWO  = 2;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                           OP_MOD = 3'd4, OP_NEG = 3'd5, OP_DUP = 3'd6, OP_CLR = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DIVIDE, FIX} state_t;

    function automatic logic [2*WIDTH-1:0] ext(input logic [WIDTH-1:0] v);
        return (SIGNED != 0) ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return (SIGNED != 0 && v < 0) ? WIDTH'(-v) : v;
    endfunction

    function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, r);
        if (SIGNED != 0) return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return r < a;
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, r);
        if (SIGNED != 0) return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return a < b;
    endfunction

    function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p);
        if (SIGNED != 0) return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
        return |p[2*WIDTH-1:WIDTH];
    endfunction

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   stack [DEPTH];
    logic [AW-1:0]      tos_idx, nos_idx, push_idx;
    logic [WIDTH-1:0]   opa, opb;
    logic               any_err, go_div;
    logic               tok_is_op;
    logic [2:0]         tok_op;
    logic [WIDTH-1:0]   tok_val;
    logic [WIDTH-1:0]   quo, rem, dvs;
    logic               neg_q, neg_r, min_ovf;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   sum, diff, div_res;
    logic [2*WIDTH-1:0] prod;

    assign tos_idx  = AW'(depth - ONE);
    assign nos_idx  = AW'(depth - TWO);
    assign push_idx = depth[AW-1:0];
    assign opb      = stack[tos_idx];
    assign opa      = stack[nos_idx];
    assign top      = (depth == '0) ? '0 : opb;
    assign any_err  = err_full | err_empty | err_div0 | err_ovf;
    assign go_div   = in_is_op && (in_op == OP_DIV || in_op == OP_MOD) && !any_err
                      && depth >= TWO && opb != '0;

    assign sum     = opa + opb;
    assign diff    = opa - opb;
    assign prod    = ext(opa) * ext(opb);
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign div_res = (tok_op == OP_MOD) ? (neg_r ? '0 - rem : rem) : (neg_q ? '0 - quo : quo);

    logic               wr_en, clr, set_full, set_empty, set_div0, set_ovf;
    logic [AW-1:0]      wr_idx;
    logic [WIDTH-1:0]   wr_data;
    logic [AW:0]        depth_nxt;

    // Decode of the latched token; consumed only in EXEC, where the stack is still unchanged.
    always_comb begin
        wr_en = 1'b0; wr_idx = tos_idx; wr_data = '0; depth_nxt = depth; clr = 1'b0;
        set_full = 1'b0; set_empty = 1'b0; set_div0 = 1'b0; set_ovf = 1'b0;
        if (tok_is_op && tok_op == OP_CLR) begin
            clr = 1'b1;
        end else if (!any_err) begin
            if (!tok_is_op) begin
                if (depth == FULL) set_full = 1'b1;
                else begin
                    wr_en = 1'b1; wr_idx = push_idx; wr_data = tok_val; depth_nxt = depth + ONE;
                end
            end else begin
                case (tok_op)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        if (depth < TWO) set_empty = 1'b1;
                        else begin
                            wr_en = 1'b1; wr_idx = nos_idx; depth_nxt = depth - ONE;
                            case (tok_op)
                                OP_ADD:  begin wr_data = sum;  set_ovf = add_ovf(opa, opb, sum);  end
                                OP_SUB:  begin wr_data = diff; set_ovf = sub_ovf(opa, opb, diff); end
                                default: begin wr_data = prod[WIDTH-1:0]; set_ovf = mul_ovf(prod); end
                            endcase
                        end
                    end
                    // A legal DIV/MOD never reaches EXEC, so here the divisor must be zero.
                    OP_DIV, OP_MOD: begin
                        if (depth < TWO) set_empty = 1'b1;
                        else set_div0 = 1'b1;
                    end
                    OP_NEG: begin
                        if (depth == '0) set_empty = 1'b1;
                        else begin
                            wr_en = 1'b1; wr_data = '0 - opb;
                            set_ovf = (SIGNED != 0) && (opb == MIN);
                        end
                    end
                    OP_DUP: begin
                        if (depth == '0) set_empty = 1'b1;
                        else if (depth == FULL) set_full = 1'b1;
                        else begin
                            wr_en = 1'b1; wr_idx = push_idx; wr_data = opb; depth_nxt = depth + ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE; in_ready <= 1'b1; depth <= '0; done <= 1'b0; cnt <= '0;
            err_full <= 1'b0; err_empty <= 1'b0; err_div0 <= 1'b0; err_ovf <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    cnt      <= '0;
                    state    <= go_div ? DIVIDE : EXEC;
                end
                EXEC: begin
                    done <= 1'b1; in_ready <= 1'b1; state <= IDLE;
                    if (clr) begin
                        depth <= '0;
                        err_full <= 1'b0; err_empty <= 1'b0; err_div0 <= 1'b0; err_ovf <= 1'b0;
                    end else begin
                        depth     <= depth_nxt;
                        err_full  <= err_full  | set_full;
                        err_empty <= err_empty | set_empty;
                        err_div0  <= err_div0  | set_div0;
                        err_ovf   <= err_ovf   | set_ovf;
                    end
                end
                // cnt==0 loads magnitudes, cnt 1..WIDTH each retire one quotient bit.
                DIVIDE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH)) state <= FIX;
                end
                FIX: begin
                    done <= 1'b1; in_ready <= 1'b1; state <= IDLE;
                    depth   <= depth - ONE;
                    err_ovf <= err_ovf | min_ovf;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            tok_is_op <= in_is_op; tok_op <= in_op; tok_val <= in_value;
        end
        if (state == EXEC && wr_en) stack[wr_idx] <= wr_data;
        if (state == FIX) stack[nos_idx] <= div_res;
        if (state == DIVIDE) begin
            if (cnt == '0) begin
                quo     <= mag(opa);
                dvs     <= mag(opb);
                rem     <= '0;
                neg_q   <= (SIGNED != 0) && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                neg_r   <= (SIGNED != 0) && opa[WIDTH-1];
                min_ovf <= (SIGNED != 0) && (opa == MIN) && (opb == '1);
            end else begin
                quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed bench for rpn_stack_engine: a signed and an unsigned instance,
// each token's latency, stack top/depth and sticky flags checked against hand values.
module tb_rpn_stack_engine;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_is_op = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_value = '0;
    logic        valid_s = 1'b0, valid_u = 1'b0;
    logic        ready_s, ready_u, done_s, done_u;
    logic [31:0] top_s, top_u;
    logic [2:0]  depth_s, depth_u;
    logic        ef_s, ee_s, ed_s, eo_s, ef_u, ee_u, ed_u, eo_u;

    bit          sel = 1'b0;
    int          tests = 0, fails = 0, lat = 0;
    bit          busy_ok, saw_done;

    wire         cur_ready = sel ? ready_u : ready_s;
    wire         cur_done  = sel ? done_u  : done_s;
    wire [31:0]  cur_top   = sel ? top_u   : top_s;
    wire [2:0]   cur_depth = sel ? depth_u : depth_s;
    wire [3:0]   cur_errs  = sel ? {ef_u, ee_u, ed_u, eo_u} : {ef_s, ee_s, ed_s, eo_s};

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
                           MOD = 3'd4, NEG = 3'd5, DUP = 3'd6, CLR = 3'd7;
    localparam logic [3:0] E_FULL = 4'b1000, E_EMPTY = 4'b0100, E_DIV0 = 4'b0010, E_OVF = 4'b0001;

    rpn_stack_engine #(.WIDTH(32), .DEPTH(4), .SIGNED(1)) u_s (
        .clk(clk), .reset_n(reset_n), .in_valid(valid_s), .in_ready(ready_s),
        .in_is_op(in_is_op), .in_value(in_value), .in_op(in_op),
        .top(top_s), .depth(depth_s), .done(done_s),
        .err_full(ef_s), .err_empty(ee_s), .err_div0(ed_s), .err_ovf(eo_s));

    rpn_stack_engine #(.WIDTH(32), .DEPTH(4), .SIGNED(0)) u_u (
        .clk(clk), .reset_n(reset_n), .in_valid(valid_u), .in_ready(ready_u),
        .in_is_op(in_is_op), .in_value(in_value), .in_op(in_op),
        .top(top_u), .depth(depth_u), .done(done_u),
        .err_full(ef_u), .err_empty(ee_u), .err_div0(ed_u), .err_ovf(eo_u));

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tok(input bit is_op, input logic [2:0] op, input logic [31:0] v);
        int n = 0;
        while (cur_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("ready_timeout", {31'b0, cur_ready}, 32'd1);
        in_is_op = is_op; in_op = op; in_value = v;
        if (sel) valid_u = 1'b1; else valid_s = 1'b1;
        @(posedge clk); #1;
        valid_s = 1'b0; valid_u = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (cur_done !== 1'b1 && lat < 200) begin
            if (cur_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic push(input logic [31:0] v); tok(1'b0, 3'd0, v); endtask
    task automatic op(input logic [2:0] o);    tok(1'b1, o, 32'd0); endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_top", top_s, 32'd0);
        chk("rst_depth", {29'b0, depth_s}, 32'd0);
        chk("rst_done", {31'b0, done_s}, 32'd0);
        chk("rst_errs", {28'b0, ef_s, ee_s, ed_s, eo_s}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'b0, ready_s}, 32'd1);

        // 7 - 5
        push(32'd7);
        chk("push_lat", lat, 32'd1);
        push(32'd5);
        op(SUB);
        chk("sub_lat", lat, 32'd1);
        chk("sub_top", top_s, 32'd2);
        chk("sub_depth", {29'b0, depth_s}, 32'd1);
        chk("sub_errs", {28'b0, cur_errs}, 32'd0);

        // -7 / 2 and -7 % 2
        op(CLR);
        push(32'hFFFF_FFF9); push(32'd2);
        op(DIV);
        chk("div_lat", lat, 32'd34);
        chk("div_busy", {31'b0, busy_ok}, 32'd1);
        chk("div_top", top_s, 32'hFFFF_FFFD);
        chk("div_depth", {29'b0, depth_s}, 32'd1);
        chk("div_ready_after", {31'b0, ready_s}, 32'd1);
        op(CLR);
        push(32'hFFFF_FFF9); push(32'd2);
        op(MOD);
        chk("mod_lat", lat, 32'd34);
        chk("mod_top", top_s, 32'hFFFF_FFFF);

        // overflow of the stack, discard while flagged, CLR recovery
        op(CLR);
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        chk("full_depth4", {29'b0, depth_s}, 32'd4);
        push(32'd9);
        chk("full_flag", {28'b0, cur_errs}, {28'b0, E_FULL});
        chk("full_depth", {29'b0, depth_s}, 32'd4);
        chk("full_top", top_s, 32'd4);
        op(ADD);
        chk("discard_lat", lat, 32'd1);
        chk("discard_top", top_s, 32'd4);
        chk("discard_depth", {29'b0, depth_s}, 32'd4);
        op(CLR);
        chk("clr_depth", {29'b0, depth_s}, 32'd0);
        chk("clr_top", top_s, 32'd0);
        chk("clr_errs", {28'b0, cur_errs}, 32'd0);

        // too few operands, divide by zero
        push(32'd3);
        op(ADD);
        chk("empty_flag", {28'b0, cur_errs}, {28'b0, E_EMPTY});
        chk("empty_top", top_s, 32'd3);
        chk("empty_depth", {29'b0, depth_s}, 32'd1);
        op(CLR);
        push(32'd5); push(32'd0);
        op(DIV);
        chk("div0_lat", lat, 32'd1);
        chk("div0_flag", {28'b0, cur_errs}, {28'b0, E_DIV0});
        chk("div0_depth", {29'b0, depth_s}, 32'd2);
        chk("div0_top", top_s, 32'd0);

        // MIN / -1
        op(CLR);
        push(32'h8000_0000); push(32'hFFFF_FFFF);
        op(DIV);
        chk("minm1_lat", lat, 32'd34);
        chk("minm1_top", top_s, 32'h8000_0000);
        chk("minm1_flag", {28'b0, cur_errs}, {28'b0, E_OVF});
        chk("minm1_depth", {29'b0, depth_s}, 32'd1);

        // MUL, signed ADD overflow
        op(CLR);
        push(32'd6); push(32'hFFFF_FFFD);
        op(MUL);
        chk("mul_top", top_s, 32'hFFFF_FFEE);
        chk("mul_errs", {28'b0, cur_errs}, 32'd0);
        push(32'h7FFF_FFFF); push(32'h7FFF_FFFF);
        op(ADD);
        chk("sadd_top", top_s, 32'hFFFF_FFFE);
        chk("sadd_depth", {29'b0, depth_s}, 32'd2);
        chk("sadd_flag", {28'b0, cur_errs}, {28'b0, E_OVF});

        // NEG of MIN, DUP/ADD/NEG chain
        op(CLR);
        push(32'h8000_0000);
        op(NEG);
        chk("negmin_top", top_s, 32'h8000_0000);
        chk("negmin_flag", {28'b0, cur_errs}, {28'b0, E_OVF});
        op(CLR);
        push(32'd5);
        op(DUP);
        chk("dup_depth", {29'b0, depth_s}, 32'd2);
        chk("dup_top", top_s, 32'd5);
        op(ADD);
        chk("dupadd_top", top_s, 32'd10);
        op(NEG);
        chk("neg_top", top_s, 32'hFFFF_FFF6);
        chk("neg_errs", {28'b0, cur_errs}, 32'd0);

        // unsigned instance
        sel = 1'b1;
        push(32'hFFFF_FFFF); push(32'd1);
        op(ADD);
        chk("uadd_top", top_u, 32'd0);
        chk("uadd_flag", {28'b0, cur_errs}, {28'b0, E_OVF});
        chk("uadd_depth", {29'b0, depth_u}, 32'd1);
        op(CLR);
        push(32'hFFFF_FFF9); push(32'd2);
        op(DIV);
        chk("udiv_lat", lat, 32'd34);
        chk("udiv_top", top_u, 32'h7FFF_FFFC);
        push(32'd5);
        op(NEG);
        chk("uneg_top", top_u, 32'hFFFF_FFFB);
        chk("uneg_errs", {28'b0, cur_errs}, 32'd0);
        sel = 1'b0;

        // reset asserted in the middle of a divide
        op(CLR);
        push(32'd20); push(32'd3);
        in_is_op = 1'b1; in_op = DIV; valid_s = 1'b1;
        @(posedge clk); #1;
        valid_s = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("middiv_busy", {31'b0, ready_s}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("middiv_top", top_s, 32'd0);
        chk("middiv_depth", {29'b0, depth_s}, 32'd0);
        chk("middiv_done", {31'b0, done_s}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done_s === 1'b1) saw_done = 1'b1; end
        reset_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done_s === 1'b1) saw_done = 1'b1; end
        chk("middiv_nodone", {31'b0, saw_done}, 32'd0);
        chk("middiv_ready", {31'b0, ready_s}, 32'd1);
        push(32'd8);
        chk("post_rst_top", top_s, 32'd8);
        chk("post_rst_depth", {29'b0, depth_s}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
